// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: issues credit-limited reads into a 2-entry in-order
// output buffer and presents buffered words on a valid/ready interface.
module fifo_rd_ctrl #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_underflow,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   output logic [FIFO_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic                  err_underflow
);

   typedef enum logic [1:0] {
      OCC_0 = 2'd0,
      OCC_1 = 2'd1,
      OCC_2 = 2'd2
   } occ_t;

   occ_t                  occ;
   occ_t                  occ_nxt;
   logic                  inflight;
   logic [FIFO_WIDTH-1:0] slot0;
   logic [FIFO_WIDTH-1:0] slot1;
   logic                  pop;
   logic                  capture;
   logic [2:0]            credit;

   // Occupancy state register
   always_ff @(posedge clk) begin
      if (rst) begin
         occ <= OCC_0;
      end else begin
         occ <= occ_nxt;
      end
   end

   // Occupancy next state
   always_comb begin
      occ_nxt = occ;
      case (occ)
         OCC_0: if (capture) occ_nxt = OCC_1;
         OCC_1: begin
            if (capture && !pop) begin
               occ_nxt = OCC_2;
            end else if (!capture && pop) begin
               occ_nxt = OCC_0;
            end
         end
         OCC_2: if (pop && !capture) occ_nxt = OCC_1;
         default: occ_nxt = OCC_0;
      endcase
   end

   // Outputs and handshake terms; a word read under underflow is dropped
   always_comb begin
      m_valid    = (occ != OCC_0);
      m_data     = slot0;
      pop        = m_valid && m_ready;
      capture    = inflight && !fifo_underflow;
      credit     = 3'd2 - {1'b0, occ} - {2'b00, inflight} + {2'b00, pop};
      fifo_rd_en = en && !fifo_empty && (credit != 3'd0) && !rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight      <= 1'b0;
         slot0         <= '0;
         slot1         <= '0;
         rd_count      <= '0;
         err_underflow <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
         if (fifo_underflow) begin
            err_underflow <= 1'b1;
         end
         if (pop) begin
            rd_count <= rd_count + 1'b1;
         end
         // slot0 is always the oldest word; a pop shifts slot1 forward
         if (pop) begin
            slot0 <= (capture && occ == OCC_1) ? fifo_data_out : slot1;
            if (capture && occ == OCC_2) begin
               slot1 <= fifo_data_out;
            end
         end else if (capture) begin
            if (occ == OCC_0) begin
               slot0 <= fifo_data_out;
            end else begin
               slot1 <= fifo_data_out;
            end
         end
      end
   end

endmodule
